// File: rtl/lfsr_stream.sv
// ---------------------------------------------------------------------------
// lfsr_stream
//
// Configurable-length LFSR word generator with a valid/ready output stream.
// Each produced word is the register state after S = shift+1 single steps,
// in either Fibonacci or Galois form, for a register of length L = len+1.
//
// Optional feature macro: LFSR_STREAM_LOCKUP_EN
//   defined   : a load or advance that would leave the register all-zero
//               forces the state to 1 and pulses lockup_o for one cycle.
//   undefined : an all-zero state persists and lockup_o is tied low.
//
// Ports
//   clk_i      sole clock, rising edge
//   rstn_i     asynchronous active-low reset
//   load_i     capture seed and configuration (wins over everything else)
//   seed_i     initial state, bits >= L are discarded
//   poly_i     polynomial, bit k is the coefficient of x^k
//   len_i      register length L = len_i + 1
//   shift_i    steps per word S = shift_i + 1
//   mode_i     0 = Fibonacci, 1 = Galois
//   en_i       request a new word
//   ready_i    consumer accepts data_o
//   valid_o    data_o holds an unconsumed word
//   data_o     current register state, bits >= L are zero
//   err_o      sticky: the loaded polynomial has no x^L term
//   lockup_o   one-cycle pulse on all-zero recovery
//   cnt_o      number of accepted words, wraps
// ---------------------------------------------------------------------------
module lfsr_stream #(
  parameter  int MAX_LEN = 32,
  parameter  int CNT_W   = 32,
  localparam int LW      = $clog2(MAX_LEN)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               load_i,
  input  logic [MAX_LEN-1:0] seed_i,
  input  logic [MAX_LEN:0]   poly_i,
  input  logic [LW-1:0]      len_i,
  input  logic [LW-1:0]      shift_i,
  input  logic               mode_i,
  input  logic               en_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [MAX_LEN-1:0] data_o,
  output logic               err_o,
  output logic               lockup_o,
  output logic [CNT_W-1:0]   cnt_o
);

  // Handshake: a word is transferred on every rising edge where
  // valid_o & ready_i. While valid_o is high and ready_i is low, data_o and
  // valid_o are frozen. A new word is produced when en_i is high and the
  // output slot is empty or being emptied on the same edge.

  // Mask with ones in bit positions below the register length.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] len);
    logic [MAX_LEN-1:0] m;
    for (int k = 0; k < MAX_LEN; k++) begin
      m[k] = (LW'(k) <= len);
    end
    return m;
  endfunction

  // One LFSR step. poly carries coefficients x^1..x^MAX_LEN; x^0 never
  // enters either recurrence (Galois injects a constant 1 in its place).
  function automatic logic [MAX_LEN-1:0] lfsr_step(
    input logic [MAX_LEN-1:0] s,
    input logic [MAX_LEN:1]   poly,
    input logic [MAX_LEN-1:0] mask,
    input logic [LW-1:0]      len,
    input logic               mode
  );
    logic               fb;
    logic               msb;
    logic [MAX_LEN-1:0] nxt;
    // poly[k] lines up with s[k-1] because poly is indexed from 1.
    fb  = ^(poly & s & mask);
    msb = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (LW'(k) == len) msb = s[k];
    end
    if (mode) begin
      nxt = ((s << 1) ^ (msb ? {poly[MAX_LEN-1:1], 1'b1} : '0)) & mask;
    end else begin
      nxt = ((s << 1) | {{(MAX_LEN-1){1'b0}}, fb}) & mask;
    end
    return nxt;
  endfunction

  logic [MAX_LEN-1:0] state_q, state_d;
  logic               valid_q, valid_d;
  logic               err_q,   err_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [LW-1:0]      len_q,   len_d;
  logic [LW-1:0]      shift_q, shift_d;
  logic               mode_q,  mode_d;
  logic [MAX_LEN:1]   poly_q,  poly_d;
  // Cleared by reset so that nothing advances until a configuration has
  // been loaded after reset.
  logic               loaded_q, loaded_d;

  logic               advance;
  logic               accept;
  logic               poly_top;
  logic [MAX_LEN-1:0] cur_mask;
  logic [MAX_LEN-1:0] adv_state;
  logic               poly0_unused;

  assign poly0_unused = poly_i[0];

  assign accept  = valid_q & ready_i;
  assign advance = en_i & ~load_i & loaded_q & (~valid_q | ready_i);

  // Coefficient of x^L for the length being loaded; an out-of-range length
  // finds no match and reads as a missing top term.
  always_comb begin
    poly_top = 1'b0;
    for (int k = 1; k <= MAX_LEN; k++) begin
      if (LW'(k - 1) == len_i) poly_top = poly_i[k];
    end
  end

  // S single steps unrolled into one combinational chain.
  always_comb begin
    cur_mask  = len_mask(len_q);
    adv_state = state_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) <= shift_q) begin
        adv_state = lfsr_step(adv_state, poly_q, cur_mask, len_q, mode_q);
      end
    end
  end

`ifdef LFSR_STREAM_LOCKUP_EN
  logic lockup_q, lockup_d;
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    shift_d  = shift_q;
    mode_d   = mode_q;
    poly_d   = poly_q;
    loaded_d = loaded_q;
    if (load_i) begin
      len_d    = len_i;
      shift_d  = shift_i;
      mode_d   = mode_i;
      poly_d   = poly_i[MAX_LEN:1];
      state_d  = seed_i & len_mask(len_i);
      valid_d  = 1'b0;
      err_d    = ~poly_top;
      cnt_d    = '0;
      loaded_d = 1'b1;
    end else begin
      if (accept) cnt_d = cnt_q + CNT_W'(1);
      if (advance) begin
        state_d = adv_state;
        valid_d = 1'b1;
      end else if (accept) begin
        valid_d = 1'b0;
      end
    end
`ifdef LFSR_STREAM_LOCKUP_EN
    lockup_d = 1'b0;
    if ((load_i || advance) && (state_d == '0)) begin
      state_d  = {{(MAX_LEN-1){1'b0}}, 1'b1};
      lockup_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      len_q    <= LW'(MAX_LEN - 1);
      shift_q  <= '0;
      mode_q   <= 1'b0;
      poly_q   <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      shift_q  <= shift_d;
      mode_q   <= mode_d;
      poly_q   <= poly_d;
      loaded_q <= loaded_d;
    end
  end

`ifdef LFSR_STREAM_LOCKUP_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) lockup_q <= 1'b0;
    else         lockup_q <= lockup_d;
  end
  assign lockup_o = lockup_q;
`else
  assign lockup_o = 1'b0;
`endif

  assign valid_o = valid_q;
  assign data_o  = state_q;
  assign err_o   = err_q;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stream
//
// Bench for lfsr_stream with MAX_LEN = 8 and CNT_W = 8 (so the word counter
// wraps quickly). A reference model computes each produced word from the
// polynomial arithmetic and pushes it into exp_q; a negedge monitor pops and
// compares whenever the design presents a word that is being accepted.
// Honours LFSR_STREAM_LOCKUP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_lfsr_stream;
  localparam int ML = 8;
  localparam int CW = 8;
  localparam int LW = $clog2(ML);

  logic          clk;
  logic          rstn;
  logic          load;
  logic [ML-1:0] seed;
  logic [ML:0]   poly;
  logic [LW-1:0] len;
  logic [LW-1:0] shift;
  logic          mode;
  logic          en;
  logic          ready;
  logic          valid_o;
  logic [ML-1:0] data_o;
  logic          err_o;
  logic          lockup_o;
  logic [CW-1:0] cnt_o;

  lfsr_stream #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .load_i   (load),
    .seed_i   (seed),
    .poly_i   (poly),
    .len_i    (len),
    .shift_i  (shift),
    .mode_i   (mode),
    .en_i     (en),
    .ready_i  (ready),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .err_o    (err_o),
    .lockup_o (lockup_o),
    .cnt_o    (cnt_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [ML-1:0] exp_q[$];

  // Reference model state (what the design should hold right now)
  logic [ML-1:0] m_state;
  bit            m_valid;
  bit            m_err;
  bit            m_lock;
  bit            m_loaded;
  int            m_l;
  int            m_s;
  bit            m_mode;
  logic [ML:0]   m_poly;
  logic [CW-1:0] m_cnt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One step of the recurrence, straight from the polynomial definition.
  function automatic logic [63:0] ref_step(input logic [63:0] s, input logic [63:0] p,
                                           input int l, input bit md);
    logic [63:0] lim;
    logic [63:0] r;
    logic        fb;
    lim = (64'd1 << l) - 64'd1;
    if (!md) begin
      fb = 1'b0;
      for (int k = 1; k <= l; k++) fb = fb ^ (p[k] & s[k-1]);
      r = ((s << 1) | {63'd0, fb}) & lim;
    end else begin
      r = (s << 1) & lim;
      if (s[l-1]) r = r ^ ((p & lim) | 64'd1);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state  = '0;
    m_valid  = 0;
    m_err    = 0;
    m_lock   = 0;
    m_loaded = 0;
    m_l      = ML;
    m_s      = 1;
    m_mode   = 0;
    m_poly   = '0;
    m_cnt    = '0;
    exp_q.delete();
  endtask

  // Driver: predict the effect of the inputs currently applied, let one
  // rising edge pass, then publish the prediction.
  task automatic tick();
    logic [ML-1:0] n_state;
    bit            n_valid, n_err, n_lock, n_loaded, n_mode;
    int            n_l, n_s;
    logic [ML:0]   n_poly;
    logic [CW-1:0] n_cnt;
    logic [63:0]   s;
    bit            flush, push, acc, adv;
    n_state = m_state; n_valid = m_valid; n_err = m_err; n_lock = 0;
    n_loaded = m_loaded; n_l = m_l; n_s = m_s; n_mode = m_mode;
    n_poly = m_poly; n_cnt = m_cnt;
    flush = 0; push = 0;
    if (load) begin
      n_l      = int'(len) + 1;
      n_s      = int'(shift) + 1;
      n_mode   = mode;
      n_poly   = poly;
      n_state  = ML'(64'(seed) & ((64'd1 << n_l) - 64'd1));
      n_valid  = 0;
      n_err    = !poly[n_l];
      n_cnt    = '0;
      n_loaded = 1;
      flush    = 1;
`ifdef LFSR_STREAM_LOCKUP_EN
      if (n_state == '0) begin n_state = 1; n_lock = 1; end
`endif
    end else begin
      acc = m_valid && ready;
      adv = en && m_loaded && (!m_valid || ready);
      if (acc) n_cnt = m_cnt + 1'b1;
      if (adv) begin
        s = 64'(m_state);
        repeat (m_s) s = ref_step(s, 64'(m_poly), m_l, m_mode);
        n_state = ML'(s);
        n_valid = 1;
        push    = 1;
`ifdef LFSR_STREAM_LOCKUP_EN
        if (n_state == '0) begin n_state = 1; n_lock = 1; end
`endif
      end else if (acc) begin
        n_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    if (!rstn) begin
      model_reset();
    end else begin
      m_state = n_state; m_valid = n_valid; m_err = n_err; m_lock = n_lock;
      m_loaded = n_loaded; m_l = n_l; m_s = n_s; m_mode = n_mode;
      m_poly = n_poly; m_cnt = n_cnt;
      if (flush) exp_q.delete();
      if (push) exp_q.push_back(n_state);
    end
  endtask

  task automatic load_cfg(input logic [ML-1:0] sd, input logic [ML:0] p,
                          input int l_f, input int s_f, input bit md);
    load  = 1;
    seed  = sd;
    poly  = p;
    len   = LW'(l_f);
    shift = LW'(s_f);
    mode  = md;
    en    = 1'($urandom_range(0, 1));
    ready = 1'($urandom_range(0, 1));
    tick();
    load  = 0;
    // Configuration inputs are scrambled afterwards; they must be ignored.
    seed  = ML'($urandom);
    poly  = (ML+1)'($urandom);
    len   = LW'($urandom);
    shift = LW'($urandom);
    mode  = 1'($urandom_range(0, 1));
  endtask

  // Monitor: compares design outputs with the model away from the edge and
  // pops the scoreboard when the presented word is accepted.
  always @(negedge clk) begin
    check("valid", valid_o, m_valid);
    check("cnt", cnt_o, m_cnt);
    check("err", err_o, m_err);
    check("lockup", lockup_o, m_lock);
    check("state", data_o, m_state);
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        check("word_present", 0, 1);
      end else begin
        check("word", data_o, exp_q[0]);
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  logic [ML-1:0] fib_exp[4];
  logic [ML-1:0] gal_exp[4];
  logic [ML-1:0] held;
  int            n_acc;

  initial begin
    fib_exp = '{8'h2, 8'h4, 8'h9, 8'h3};
    gal_exp = '{8'h2, 8'h4, 8'h8, 8'h9};
    rstn = 0; load = 0; seed = '0; poly = '0; len = '0; shift = '0;
    mode = 0; en = 0; ready = 0;
    model_reset();
    repeat (3) tick();
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_lockup", lockup_o, 0);
    check("rst_cnt", cnt_o, 0);
    rstn = 1;
    // No load yet: enable alone must not produce a word.
    en = 1; ready = 1;
    repeat (3) tick();
    check("noload_valid", valid_o, 0);

    // Fibonacci x^4+x^3+1, seed 1
    load_cfg(8'h1, 9'b11001, 3, 0, 0);
    check("fib_err", err_o, 0);
    en = 1; ready = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i < 4) check("fib_seq", data_o, fib_exp[i]);
    end
    check("fib_period", data_o, 8'h1);
    en = 0;
    tick();
    check("fib_cnt15", cnt_o, 15);
    check("fib_drain_valid", valid_o, 0);
    check("fib_drain_hold", data_o, 8'h1);

    // Galois, same polynomial
    load_cfg(8'h1, 9'b11001, 3, 0, 1);
    en = 1; ready = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i < 4) check("gal_seq", data_o, gal_exp[i]);
    end
    check("gal_period", data_o, 8'h1);

    // Three steps per word: 1->2->4->9, then 9->3->6->D
    load_cfg(8'h1, 9'b11001, 3, 2, 0);
    en = 1; ready = 1;
    tick();
    check("multi_w1", data_o, 8'h9);
    tick();
    check("multi_w2", data_o, 8'hD);

    // Backpressure
    load_cfg(8'h1, 9'b11001, 3, 0, 0);
    en = 1; ready = 0;
    tick();
    held = data_o;
    check("bp_first", data_o, 8'h2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", data_o, held);
      check("bp_hold_valid", valid_o, 1);
      check("bp_hold_cnt", cnt_o, 0);
    end
    ready = 1;
    tick();
    ready = 0;
    check("bp_one_adv", data_o, 8'h4);
    check("bp_cnt1", cnt_o, 1);
    tick();
    check("bp_after", data_o, 8'h4);

    // All-zero seed
    load_cfg(8'h0, 9'b11001, 3, 0, 0);
`ifdef LFSR_STREAM_LOCKUP_EN
    check("lock_state", data_o, 8'h1);
    check("lock_pulse", lockup_o, 1);
    en = 0; ready = 1;
    tick();
    check("lock_pulse_end", lockup_o, 0);
`else
    check("zero_state", data_o, 8'h0);
    check("zero_nolock", lockup_o, 0);
    en = 1; ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zero_persist", data_o, 8'h0);
      check("zero_valid", valid_o, 1);
    end
`endif

    // Polynomial without x^L term: sticky error, still advancing
    load_cfg(8'h1, 9'b01001, 3, 0, 0);
    check("err_set", err_o, 1);
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom_range(0, 1)); ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("err_sticky", err_o, 1);
    load_cfg(8'h1, 9'b11001, 3, 0, 0);
    check("err_clear", err_o, 0);

    // Reset in the middle of a stream
    en = 1; ready = 0;
    repeat (3) tick();
    rstn = 0;
    model_reset();
    #1;
    check("arst_data", data_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_err", err_o, 0);
    check("arst_cnt", cnt_o, 0);
    repeat (2) tick();
    rstn = 1;
    en = 1; ready = 1;
    tick();
    check("arst_noadv", valid_o, 0);

    // Counter wrap (8-bit counter)
    load_cfg(8'h5A, 9'h11D, 7, int'($urandom_range(0, 7)), 0);
    en = 1; ready = 1;
    n_acc = 260;
    repeat (n_acc) tick();
    en = 0;
    tick();
    check("cnt_wrap", cnt_o, CW'(n_acc));

    // Randomized configurations and handshakes
    for (int r = 0; r < 30; r++) begin
      load_cfg(ML'($urandom), (ML+1)'($urandom), int'($urandom_range(0, ML-1)),
               int'($urandom_range(0, ML-1)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 24) == 0) begin
          load_cfg(ML'($urandom), (ML+1)'($urandom), int'($urandom_range(0, ML-1)),
                   int'($urandom_range(0, ML-1)), 1'($urandom_range(0, 1)));
        end else begin
          en    = ($urandom_range(0, 3) != 0);
          ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    end

    en = 0; ready = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
